mem_access_unit: RTL and testbench

- Load/store initiator that drives the DataMemory port set: Address, WriteData, MemRead, MemWrite and ReadData.
- Accepts byte, half and word requests from the datapath, and returns sign- or zero-extended load data.
- Implements sub-word stores as a read-modify-write, because DataMemory writes whole words only.
- Sits between the ALU/datapath and DataMemory.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_lane_align.sv | 65 ++++++
 rtl/mem_access_unit.sv | 146 ++++++++++++++
 tb/tb_mem_access_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: request size encodings,
// FSM state type and small decode helpers.
package mem_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } memState_t;

    // Size code 11 behaves exactly like a word access.
    function automatic logic [1:0] normSize(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : sz;
    endfunction

    // True when the low address bits do not match the natural alignment.
    function automatic logic isMisaligned(input logic [1:0] sz, input logic [1:0] addrLo);
        logic mis;
        mis = 1'b0;
        case (normSize(sz))
            SZ_HALF: mis = addrLo[0];
            SZ_WORD: mis = (addrLo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts/extends a byte or half from a memory
// word for loads, and merges store data into the addressed lane(s) for the
// read-modify-write path. Lanes are little-endian; DATA_W is fixed at 32.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        laneOff,
    input  logic [1:0]        size,
    input  logic              signExt,
    input  logic [DATA_W-1:0] storeData,
    output logic [DATA_W-1:0] loadVal,
    output logic [DATA_W-1:0] mergedWord
);

    localparam int LANE_W = DATA_W / WORD_BYTES;

    logic [LANE_W-1:0]   byteSel;
    logic [2*LANE_W-1:0] halfSel;

    // Select the addressed byte and half of the incoming word.
    always_comb begin
        byteSel = word[7:0];
        case (laneOff)
            2'd0: byteSel = word[7:0];
            2'd1: byteSel = word[15:8];
            2'd2: byteSel = word[23:16];
            2'd3: byteSel = word[31:24];
            default: byteSel = word[7:0];
        endcase
        halfSel = laneOff[1] ? word[31:16] : word[15:0];
    end

    // Right-justify/extend the load value and splice store data into the word.
    always_comb begin
        loadVal    = word;
        mergedWord = storeData;
        case (normSize(size))
            SZ_BYTE: begin
                loadVal    = {{(DATA_W-LANE_W){signExt & byteSel[LANE_W-1]}}, byteSel};
                mergedWord = word;
                case (laneOff)
                    2'd0: mergedWord[7:0]   = storeData[7:0];
                    2'd1: mergedWord[15:8]  = storeData[7:0];
                    2'd2: mergedWord[23:16] = storeData[7:0];
                    2'd3: mergedWord[31:24] = storeData[7:0];
                    default: mergedWord = word;
                endcase
            end
            SZ_HALF: begin
                loadVal    = {{(DATA_W-2*LANE_W){signExt & halfSel[2*LANE_W-1]}}, halfSel};
                mergedWord = word;
                if (laneOff[1]) mergedWord[31:16] = storeData[15:0];
                else            mergedWord[15:0]  = storeData[15:0];
            end
            default: begin
                loadVal    = word;
                mergedWord = storeData;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the DataMemory port set. Sub-word stores are done
// as read-modify-write because the memory only writes whole words.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word requests skip the
// memory and complete in one cycle with Fault=1.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              ReqReady,
    output logic              RespValid,
    output logic [DATA_W-1:0] RespRData,
    output logic              Fault,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] ReadData
);

    memState_t         state;
    logic [1:0]        laneQ;
    logic [1:0]        sizeQ;
    logic              signQ;
    logic              writeQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] loadVal;
    logic [DATA_W-1:0] mergedWord;
    logic [1:0]        reqSizeN;
    logic              trapReq;

    assign reqSizeN = normSize(ReqSize);

`ifdef MEM_MISALIGN_TRAP_EN
    logic faultQ;
    assign trapReq = isMisaligned(ReqSize, ReqAddr[1:0]);
    assign Fault   = faultQ;
`else
    assign trapReq = 1'b0;
    assign Fault   = 1'b0;
`endif

    mem_lane_align #(.DATA_W(DATA_W)) uAlign (
        .word       (ReadData),
        .laneOff    (laneQ),
        .size       (sizeQ),
        .signExt    (signQ),
        .storeData  (wdataQ),
        .loadVal    (loadVal),
        .mergedWord (mergedWord)
    );

    // Request FSM; every port output is a register updated here.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            ReqReady  <= 1'b1;
            RespValid <= 1'b0;
            RespRData <= '0;
            Address   <= '0;
            WriteData <= '0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            laneQ     <= 2'b00;
            sizeQ     <= SZ_BYTE;
            signQ     <= 1'b0;
            writeQ    <= 1'b0;
            wdataQ    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            faultQ    <= 1'b0;
`endif
        end else begin
            // Strobes and the response pulse are single-cycle by default.
            RespValid <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        ReqReady  <= 1'b0;
                        RespRData <= '0;
                        laneQ     <= ReqAddr[1:0];
                        sizeQ     <= reqSizeN;
                        signQ     <= ReqSigned;
                        writeQ    <= ReqWrite;
                        wdataQ    <= ReqWData;
`ifdef MEM_MISALIGN_TRAP_EN
                        faultQ    <= trapReq;
`endif
                        if (trapReq) begin
                            // Misaligned: no memory traffic, Address left untouched.
                            state     <= RESP;
                            RespValid <= 1'b1;
                        end else if (ReqWrite && reqSizeN == SZ_WORD) begin
                            state     <= WR;
                            Address   <= {ReqAddr[ADDR_W-1:2], 2'b00};
                            WriteData <= ReqWData;
                            MemWrite  <= 1'b1;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state     <= RD;
                            Address   <= {ReqAddr[ADDR_W-1:2], 2'b00};
                            MemRead   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (writeQ) begin
                        state     <= WR;
                        WriteData <= mergedWord;
                        MemWrite  <= 1'b1;
                    end else begin
                        state     <= RESP;
                        RespRData <= loadVal;
                        RespValid <= 1'b1;
                    end
                end
                WR: begin
                    state     <= RESP;
                    RespValid <= 1'b1;
                end
                RESP: begin
                    state    <= IDLE;
                    ReqReady <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                    faultQ   <= 1'b0;
`endif
                end
                default: begin
                    state    <= IDLE;
                    ReqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan steps followed by randomized
// requests, checked against a byte-addressed reference memory.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqWrite = 1'b0;
    logic [1:0]  ReqSize = 2'b00;
    logic        ReqSigned = 1'b0;
    logic [31:0] ReqAddr = 32'h0;
    logic [31:0] ReqWData = 32'h0;
    logic        ReqReady, RespValid, Fault, MemRead, MemWrite;
    logic [31:0] RespRData, Address, WriteData, ReadData;

    int tests = 0;
    int fails = 0;

    logic [31:0] dutMem   [256];
    logic [7:0]  refBytes [1024];

    always #5 Clk = ~Clk;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
        .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .ReqReady(ReqReady), .RespValid(RespValid), .RespRData(RespRData),
        .Fault(Fault), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
    );

    // Memory attached to the DUT: combinational read, write on rising edge.
    assign ReadData = MemRead ? dutMem[Address[9:2]] : 32'h0;
    always @(posedge Clk) if (MemWrite) dutMem[Address[9:2]] <= WriteData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refWord(input int a);
        int b;
        b = a & 32'h3FC;
        return {refBytes[b+3], refBytes[b+2], refBytes[b+1], refBytes[b]};
    endfunction

    task automatic setWord(input int a, input logic [31:0] v);
        dutMem[(a >> 2) & 255] = v;
        for (int k = 0; k < 4; k++) refBytes[(a & 32'h3FC) + k] = v[8*k +: 8];
    endtask

    // Issue one request and check everything observable about it.
    task automatic doReq(input logic wr, input logic [1:0] sz, input logic sg,
                         input int a, input logic [31:0] wd, output logic [31:0] got);
        int nb, base, lat, cyc, rdCnt, wrCnt, both, guard;
        logic mis;
        logic [31:0] expData, lastAddr, lastWData, mask;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = a & ~(nb - 1) & 32'h3FF;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (a % nb) != 0;
`else
        mis = 1'b0;
`endif
        lat = mis ? 1 : (wr && nb < 4) ? 3 : 2;
        expData = 32'h0;
        if (!wr && !mis) begin
            for (int k = 0; k < nb; k++) expData = expData + (32'(refBytes[base+k]) << (8*k));
            mask = (nb == 4) ? 32'h0 : (32'hFFFF_FFFF << (8*nb));
            if (sg && nb < 4 && expData[8*nb-1]) expData = expData | mask;
        end
        if (wr && !mis)
            for (int k = 0; k < nb; k++) refBytes[base+k] = wd[8*k +: 8];

        guard = 0;
        while (!ReqReady && guard < 20) begin @(negedge Clk); guard++; end
        chk("ready_before_req", ReqReady, 1'b1);
        ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg;
        ReqAddr = 32'(a); ReqWData = wd;
        @(posedge Clk);
        rdCnt = 0; wrCnt = 0; both = 0; lastAddr = 32'h0; lastWData = 32'h0;
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            ReqValid = 1'b0;
            cyc = c;
            if (MemRead) rdCnt++;
            if (MemWrite) begin wrCnt++; lastWData = WriteData; end
            if (MemRead || MemWrite) lastAddr = Address;
            if (MemRead && MemWrite) both++;
            if (RespValid) break;
            if (c == 10) cyc = 11;
        end
        got = RespRData;
        chk("latency", cyc, lat);
        chk("fault", Fault, mis);
        chk("rdata", RespRData, expData);
        chk("read_strobes", rdCnt, (mis || (wr && nb == 4)) ? 0 : 1);
        chk("write_strobes", wrCnt, (wr && !mis) ? 1 : 0);
        chk("no_overlap", both, 0);
        if (!mis) chk("address", lastAddr, 32'(a & 32'h3FC));
        if (wr && !mis) begin
            chk("write_data", lastWData, refWord(a));
            chk("mem_word", dutMem[(a >> 2) & 255], refWord(a));
        end
        @(negedge Clk);
        chk("resp_pulse_end", RespValid, 1'b0);
        chk("ready_after", ReqReady, 1'b1);
    endtask

    initial begin
        logic [31:0] got;
        int a;
        logic [1:0] sz;
        for (int i = 0; i < 256; i++) setWord(i * 4, $urandom);

        // Reset held for two cycles.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ready", ReqReady, 1'b1);
        chk("rst_respvalid", RespValid, 1'b0);
        chk("rst_memread", MemRead, 1'b0);
        chk("rst_memwrite", MemWrite, 1'b0);
        chk("rst_fault", Fault, 1'b0);
        chk("rst_address", Address, 32'h0);
        chk("rst_writedata", WriteData, 32'h0);
        chk("rst_rdata", RespRData, 32'h0);
        Rst_n = 1'b1;
        repeat (5) begin
            @(negedge Clk);
            chk("idle_no_strobe", MemRead | MemWrite, 1'b0);
        end

        // Word store then load.
        doReq(1'b1, 2'd2, 1'b0, 32'h1FC, 32'hDAD5B00B, got);
        doReq(1'b0, 2'd2, 1'b0, 32'h1FC, 32'h0, got);
        chk("word_load", got, 32'hDAD5B00B);

        // Byte store read-modify-write.
        setWord(32'h100, 32'h11223344);
        doReq(1'b1, 2'd0, 1'b0, 32'h102, 32'h000000AB, got);
        chk("rmw_word", dutMem[32'h100 >> 2], 32'h11AB3344);

        // Signed/unsigned sub-word loads.
        setWord(32'h180, 32'h80FF7F01);
        doReq(1'b0, 2'd0, 1'b1, 32'h181, 32'h0, got);
        chk("byte1_signed", got, 32'h0000007F);
        doReq(1'b0, 2'd0, 1'b1, 32'h182, 32'h0, got);
        chk("byte2_signed", got, 32'hFFFFFFFF);
        doReq(1'b0, 2'd1, 1'b0, 32'h182, 32'h0, got);
        chk("half2_unsigned", got, 32'h000080FF);
        doReq(1'b0, 2'd1, 1'b1, 32'h182, 32'h0, got);
        chk("half2_signed", got, 32'hFFFF80FF);

        // Reset during the write phase of a byte store.
        setWord(32'h140, 32'hCAFEF00D);
        @(negedge Clk);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqSigned = 1'b0;
        ReqAddr = 32'h141; ReqWData = 32'h55;
        @(posedge Clk);
        @(negedge Clk);
        ReqValid = 1'b0;
        chk("midrst_rd", MemRead, 1'b1);
        @(negedge Clk);
        chk("midrst_wr", MemWrite, 1'b1);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_memwrite_drop", MemWrite, 1'b0);
        chk("midrst_ready", ReqReady, 1'b1);
        repeat (2) begin
            @(negedge Clk);
            chk("midrst_no_resp", RespValid, 1'b0);
        end
        Rst_n = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("postrst_no_resp", RespValid, 1'b0);
        end
        chk("midrst_mem_kept", dutMem[32'h140 >> 2], 32'hCAFEF00D);
        doReq(1'b0, 2'd2, 1'b0, 32'h140, 32'h0, got);
        chk("midrst_old_value", got, 32'hCAFEF00D);

        // Misaligned word load.
        doReq(1'b0, 2'd2, 1'b0, 32'h103, 32'h0, got);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misaligned_trap", got, 32'h0);
`else
        chk("misaligned_ignored", got, 32'h11AB3344);
`endif

        // Randomized mix over a small window so stores and loads interact.
        for (int n = 0; n < 80; n++) begin
            a  = 32'h100 + int'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            doReq(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
